// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: status codes, instruction codes, register IDs
// and the write-back control payload held in the W pipeline register.
package y86_pkg;

    localparam int unsigned STAT_W   = 3;
    localparam int unsigned ICODE_W  = 4;
    localparam int unsigned REG_ID_W = 4;

    localparam logic [STAT_W-1:0] STAT_BUB = 3'd0;
    localparam logic [STAT_W-1:0] STAT_AOK = 3'd1;
    localparam logic [STAT_W-1:0] STAT_HLT = 3'd2;
    localparam logic [STAT_W-1:0] STAT_ADR = 3'd3;
    localparam logic [STAT_W-1:0] STAT_INS = 3'd4;

    localparam logic [ICODE_W-1:0] I_HALT   = 4'h0;
    localparam logic [ICODE_W-1:0] I_NOP    = 4'h1;
    localparam logic [ICODE_W-1:0] I_CMOVXX = 4'h2;
    localparam logic [ICODE_W-1:0] I_IRMOVQ = 4'h3;
    localparam logic [ICODE_W-1:0] I_RMMOVQ = 4'h4;
    localparam logic [ICODE_W-1:0] I_MRMOVQ = 4'h5;
    localparam logic [ICODE_W-1:0] I_OPQ    = 4'h6;
    localparam logic [ICODE_W-1:0] I_JXX    = 4'h7;
    localparam logic [ICODE_W-1:0] I_CALL   = 4'h8;
    localparam logic [ICODE_W-1:0] I_RET    = 4'h9;
    localparam logic [ICODE_W-1:0] I_PUSHQ  = 4'hA;
    localparam logic [ICODE_W-1:0] I_POPQ   = 4'hB;

    localparam logic [REG_ID_W-1:0] REG_RAX  = 4'h0;
    localparam logic [REG_ID_W-1:0] REG_RCX  = 4'h1;
    localparam logic [REG_ID_W-1:0] REG_RDX  = 4'h2;
    localparam logic [REG_ID_W-1:0] REG_RBX  = 4'h3;
    localparam logic [REG_ID_W-1:0] REG_RSP  = 4'h4;
    localparam logic [REG_ID_W-1:0] REG_RBP  = 4'h5;
    localparam logic [REG_ID_W-1:0] REG_RSI  = 4'h6;
    localparam logic [REG_ID_W-1:0] REG_RDI  = 4'h7;
    localparam logic [REG_ID_W-1:0] REG_R8   = 4'h8;
    localparam logic [REG_ID_W-1:0] REG_R9   = 4'h9;
    localparam logic [REG_ID_W-1:0] REG_R10  = 4'hA;
    localparam logic [REG_ID_W-1:0] REG_R11  = 4'hB;
    localparam logic [REG_ID_W-1:0] REG_R12  = 4'hC;
    localparam logic [REG_ID_W-1:0] REG_R13  = 4'hD;
    localparam logic [REG_ID_W-1:0] REG_R14  = 4'hE;
    localparam logic [REG_ID_W-1:0] REG_NONE = 4'hF;

    // Control half of the W register; data fields stay outside so DATA_W can vary.
    typedef struct packed {
        logic [STAT_W-1:0]   stat;
        logic [ICODE_W-1:0]  icode;
        logic [REG_ID_W-1:0] dst_e;
        logic [REG_ID_W-1:0] dst_m;
    } w_ctl_t;

    // HLT, ADR and INS stop the machine once they reach write-back.
    function automatic logic stat_is_exc(input logic [STAT_W-1:0] stat);
        return (stat == STAT_HLT) || (stat == STAT_ADR) || (stat == STAT_INS);
    endfunction

    function automatic logic id_valid(input logic [REG_ID_W-1:0] id,
                                      input logic [REG_ID_W-1:0] rnone,
                                      input int unsigned         nreg);
        return (id != rnone) && (32'(id) < nreg);
    endfunction

endpackage

// File: rtl/regfile_2w2r.sv
// Architectural register file: two write ports (E, M), two combinational
// read ports with bypass of the pending write, M port winning on conflicts.
module regfile_2w2r
    import y86_pkg::*;
#(
    parameter int unsigned         DATA_W = 64,
    parameter int unsigned         NREG   = 15,
    parameter logic [REG_ID_W-1:0] RNONE  = REG_NONE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [REG_ID_W-1:0] dst_e,
    input  logic [DATA_W-1:0]   val_e,
    input  logic [REG_ID_W-1:0] dst_m,
    input  logic [DATA_W-1:0]   val_m,
    input  logic [REG_ID_W-1:0] src_a,
    input  logic [REG_ID_W-1:0] src_b,
    output logic [DATA_W-1:0]   rval_a,
    output logic [DATA_W-1:0]   rval_b
);

    logic [DATA_W-1:0] regs [NREG];
    logic              wr_e;
    logic              wr_m;
    logic [DATA_W-1:0] stored_a;
    logic [DATA_W-1:0] stored_b;

    assign wr_e = we && id_valid(dst_e, RNONE, NREG);
    assign wr_m = we && id_valid(dst_m, RNONE, NREG);

    // Storage; M port takes precedence when both ports target one register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NREG); i++) begin
                if (wr_m && (dst_m == REG_ID_W'(i))) begin
                    regs[i] <= val_m;
                end else if (wr_e && (dst_e == REG_ID_W'(i))) begin
                    regs[i] <= val_e;
                end
            end
        end
    end

    always_comb begin
        stored_a = '0;
        stored_b = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            if (src_a == REG_ID_W'(i)) begin
                stored_a = regs[i];
            end
            if (src_b == REG_ID_W'(i)) begin
                stored_b = regs[i];
            end
        end
    end

    // A read sees the value the register will hold after this cycle's write.
    function automatic logic [DATA_W-1:0] bypass(input logic [REG_ID_W-1:0] src,
                                                 input logic [DATA_W-1:0]   stored);
        logic [DATA_W-1:0] res;
        res = '0;
        if (id_valid(src, RNONE, NREG)) begin
            if (wr_m && (dst_m == src)) begin
                res = val_m;
            end else if (wr_e && (dst_e == src)) begin
                res = val_e;
            end else begin
                res = stored;
            end
        end
        return res;
    endfunction

    assign rval_a = bypass(src_a, stored_a);
    assign rval_b = bypass(src_b, stored_b);

endmodule

// File: rtl/pipe_write_back.sv
// Y86-64 write-back stage: W pipeline register, sticky halt detection and
// the register file it updates.
module pipe_write_back
    import y86_pkg::*;
#(
    parameter int unsigned         DATA_W = 64,
    parameter int unsigned         NREG   = 15,
    parameter logic [REG_ID_W-1:0] RNONE  = 4'hF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [STAT_W-1:0]   m_stat,
    input  logic [ICODE_W-1:0]  m_icode,
    input  logic                m_cnd,
    input  logic [DATA_W-1:0]   m_valE,
    input  logic [DATA_W-1:0]   m_valM,
    input  logic [REG_ID_W-1:0] m_dstE,
    input  logic [REG_ID_W-1:0] m_dstM,
    input  logic                w_stall,
    input  logic                w_bubble,
    input  logic [REG_ID_W-1:0] srcA,
    input  logic [REG_ID_W-1:0] srcB,
    output logic [DATA_W-1:0]   rvalA,
    output logic [DATA_W-1:0]   rvalB,
    output logic [STAT_W-1:0]   w_stat,
    output logic                halted
);

    localparam w_ctl_t BUBBLE_CTL = '{
        stat:  STAT_BUB,
        icode: I_NOP,
        dst_e: RNONE,
        dst_m: RNONE
    };

    w_ctl_t            w_ctl_q;
    logic [DATA_W-1:0] w_val_e_q;
    logic [DATA_W-1:0] w_val_m_q;
    logic              halted_q;
    w_ctl_t            capture_ctl;
    logic              wr_en;

    // A cmov whose condition failed retires without an E destination.
    always_comb begin
        capture_ctl       = '0;
        capture_ctl.stat  = m_stat;
        capture_ctl.icode = m_icode;
        capture_ctl.dst_e = m_dstE;
        capture_ctl.dst_m = m_dstM;
        if ((m_icode == I_CMOVXX) && !m_cnd) begin
            capture_ctl.dst_e = RNONE;
        end
    end

    // W pipeline register: stall beats bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ctl_q   <= BUBBLE_CTL;
            w_val_e_q <= '0;
            w_val_m_q <= '0;
        end else if (!w_stall) begin
            if (w_bubble) begin
                w_ctl_q   <= BUBBLE_CTL;
                w_val_e_q <= '0;
                w_val_m_q <= '0;
            end else begin
                w_ctl_q   <= capture_ctl;
                w_val_e_q <= m_valE;
                w_val_m_q <= m_valM;
            end
        end
    end

    // Once an exception retires, the machine state is frozen until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else if (stat_is_exc(w_ctl_q.stat)) begin
            halted_q <= 1'b1;
        end
    end

    assign wr_en = !halted_q && !stat_is_exc(w_ctl_q.stat);

    regfile_2w2r #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .RNONE  (RNONE)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wr_en),
        .dst_e  (w_ctl_q.dst_e),
        .val_e  (w_val_e_q),
        .dst_m  (w_ctl_q.dst_m),
        .val_m  (w_val_m_q),
        .src_a  (srcA),
        .src_b  (srcB),
        .rval_a (rvalA),
        .rval_b (rvalB)
    );

    assign w_stat = w_ctl_q.stat;
    assign halted = halted_q;

    // While held in reset the W register must present a nop bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            assert ((w_ctl_q.icode == I_NOP) && (w_ctl_q.stat == STAT_BUB));
        end
    end

endmodule

// File: tb/tb_pipe_write_back.sv
// Directed bench for pipe_write_back: cycle-level reference model compared
// every negative edge, plus hand-computed expectations for each scenario.
module tb_pipe_write_back;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  m_stat;
    logic [3:0]  m_icode;
    logic        m_cnd;
    logic [63:0] m_valE;
    logic [63:0] m_valM;
    logic [3:0]  m_dstE;
    logic [3:0]  m_dstM;
    logic        w_stall;
    logic        w_bubble;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [63:0] rvalA;
    logic [63:0] rvalB;
    logic [2:0]  w_stat;
    logic        halted;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    localparam logic [63:0] V_IRM  = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] V_CMOV = 64'hCAFE_BABE_DEAD_BEEF;
    localparam logic [63:0] V_POPE = 64'h8877_6655_4433_2211;
    localparam logic [63:0] V_POPM = 64'hFACE_FACE_FACE_FACE;
    localparam logic [63:0] V_R7   = 64'h0707_0707_0707_0707;
    localparam logic [63:0] V_R6   = 64'h0606_0606_0606_0606;
    localparam logic [63:0] V_R5   = 64'h5555_5555_5555_5555;
    localparam logic [63:0] V_R3   = 64'h3333_3333_3333_3333;

    always #5 clk = ~clk;

    pipe_write_back dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_stat   (m_stat),
        .m_icode  (m_icode),
        .m_cnd    (m_cnd),
        .m_valE   (m_valE),
        .m_valM   (m_valM),
        .m_dstE   (m_dstE),
        .m_dstM   (m_dstM),
        .w_stall  (w_stall),
        .w_bubble (w_bubble),
        .srcA     (srcA),
        .srcB     (srcB),
        .rvalA    (rvalA),
        .rvalB    (rvalB),
        .w_stat   (w_stat),
        .halted   (halted)
    );

    // Reference model: architectural registers plus the instruction sitting in W.
    logic [63:0] mreg [16];
    logic [2:0]  ms;
    logic [3:0]  mde;
    logic [3:0]  mdm;
    logic [63:0] mve;
    logic [63:0] mvm;
    logic        mh;

    function automatic bit exc(input logic [2:0] s);
        return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
    endfunction

    function automatic bit commit_ok();
        return !mh && !exc(ms);
    endfunction

    // Architectural view of a register once the instruction in W has retired.
    function automatic logic [63:0] peek(input logic [3:0] id);
        logic [63:0] v;
        if (id >= 4'd15) return 64'd0;
        v = mreg[id];
        if (commit_ok()) begin
            if (mde == id) v = mve;
            if (mdm == id) v = mvm;
        end
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mreg[i] = 64'd0;
            ms = 3'd0; mde = 4'hF; mdm = 4'hF; mve = 64'd0; mvm = 64'd0; mh = 1'b0;
        end else begin
            for (int i = 0; i < 15; i++) mreg[i] = peek(4'(i));
            if (exc(ms)) mh = 1'b1;
            if (!w_stall) begin
                if (w_bubble) begin
                    ms = 3'd0; mde = 4'hF; mdm = 4'hF; mve = 64'd0; mvm = 64'd0;
                end else begin
                    ms  = m_stat;
                    mde = (m_icode == 4'h2 && !m_cnd) ? 4'hF : m_dstE;
                    mdm = m_dstM;
                    mve = m_valE;
                    mvm = m_valM;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_w_stat", 64'(w_stat), 64'(ms));
            chk("model_halted", 64'(halted), 64'(mh));
            chk("model_rvalA", rvalA, peek(srcA));
            chk("model_rvalB", rvalB, peek(srcB));
        end
    end

    task automatic drv(input logic [2:0] st, input logic [3:0] ic, input logic cnd,
                       input logic [63:0] ve, input logic [63:0] vm,
                       input logic [3:0] de, input logic [3:0] dm);
        m_stat = st; m_icode = ic; m_cnd = cnd;
        m_valE = ve; m_valM = vm; m_dstE = de; m_dstM = dm;
    endtask

    task automatic nop();
        drv(3'd1, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b1; w_stall = 1'b0; w_bubble = 1'b0; srcA = 4'hF; srcB = 4'hF;
        nop();
        #1 rst_n = 1'b0; srcA = 4'd1; srcB = 4'd2;
        #2;
        chk("reset_rvalA", rvalA, 64'd0);
        chk("reset_w_stat", 64'(w_stat), 64'd0);
        chk("reset_halted", 64'(halted), 64'd0);
        cmp_en = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;

        // irmovq: bypass while in W, register file one edge later
        drv(3'd1, 4'h3, 1'b0, V_IRM, 64'd0, 4'd1, 4'hF);
        tick();
        #1 chk("irmov_bypass", rvalA, V_IRM);
        nop();
        tick();
        #1 chk("irmov_reg", rvalA, V_IRM);

        // cmov not taken, then taken
        drv(3'd1, 4'h2, 1'b0, V_CMOV, 64'd0, 4'd4, 4'hF);
        tick();
        srcA = 4'd4;
        #1 chk("cmov_nt_bypass", rvalA, 64'd0);
        nop();
        tick();
        #1 chk("cmov_nt_reg", rvalA, 64'd0);
        drv(3'd1, 4'h2, 1'b1, V_CMOV, 64'd0, 4'd4, 4'hF);
        tick();
        #1 chk("cmov_t_bypass", rvalA, V_CMOV);
        nop();
        tick();
        #1 chk("cmov_t_reg", rvalA, V_CMOV);

        // popq: both ports aim at %rsp, M value wins
        drv(3'd1, 4'hB, 1'b0, V_POPE, V_POPM, 4'd4, 4'd4);
        tick();
        srcB = 4'd1;
        #1 chk("popq_bypass", rvalA, V_POPM);
        nop();
        tick();
        #1 chk("popq_reg", rvalA, V_POPM);
        chk("reg1_kept", rvalB, V_IRM);

        // stall with bubble also high holds W; bubble alone loads BUB
        drv(3'd1, 4'h3, 1'b0, V_R7, 64'd0, 4'd7, 4'hF);
        tick();
        w_stall = 1'b1; w_bubble = 1'b1;
        drv(3'd1, 4'h3, 1'b0, V_R6, 64'd0, 4'd6, 4'hF);
        srcA = 4'd7; srcB = 4'd6;
        repeat (3) tick();
        #1 chk("stall_w_stat", 64'(w_stat), 64'd1);
        chk("stall_hold_r7", rvalA, V_R7);
        chk("stall_no_r6", rvalB, 64'd0);
        w_stall = 1'b0;
        tick();
        #1 chk("bubble_w_stat", 64'(w_stat), 64'd0);
        chk("bubble_no_r6", rvalB, 64'd0);
        w_bubble = 1'b0;
        nop();
        tick();
        #1 chk("bubble_nowrite_r6", rvalB, 64'd0);

        // asynchronous reset with a write to %rbp pending in W
        drv(3'd1, 4'h3, 1'b0, V_R5, 64'd0, 4'd5, 4'hF);
        tick();
        srcA = 4'd5; srcB = 4'd1;
        #1 chk("rst_pre_bypass", rvalA, V_R5);
        rst_n = 1'b0;
        #1 chk("rst_async_rvalA", rvalA, 64'd0);
        chk("rst_async_rvalB", rvalB, 64'd0);
        chk("rst_async_w_stat", 64'(w_stat), 64'd0);
        chk("rst_async_halted", 64'(halted), 64'd0);
        nop();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
        tick();
        #1 chk("rst_r5_dropped", rvalA, 64'd0);

        // halt retires, following opq must not write %rbx
        drv(3'd2, 4'h0, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF);
        tick();
        #1 chk("hlt_not_yet", 64'(halted), 64'd0);
        chk("hlt_w_stat", 64'(w_stat), 64'd2);
        drv(3'd1, 4'h6, 1'b0, V_R3, 64'd0, 4'd3, 4'hF);
        tick();
        srcA = 4'd3;
        #1 chk("halted_set", 64'(halted), 64'd1);
        chk("halt_no_bypass", rvalA, 64'd0);
        nop();
        repeat (3) tick();
        #1 chk("halt_no_write_r3", rvalA, 64'd0);
        chk("halted_sticky", 64'(halted), 64'd1);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_write_back.md
PIPE_WRITE_BACK -- requirements
Module: pipe_write_back

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning register and value width.
REQ-002 SHALL have parameter NREG, default 15, meaning number of architectural registers (IDs 0..NREG-1).
REQ-003 SHALL have parameter RNONE, default 4'hF, meaning "no register" ID; never written, reads return 0.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous reset, active-low.
REQ-006 SHALL have port m_stat  in  3  status from memory stage (BUB=0, AOK=1, HLT=2, ADR=3, INS=4).
REQ-007 SHALL have port m_icode  in  4  instruction code from memory stage.
REQ-008 SHALL have port m_cnd  in  1  condition flag, used for cmov (icode 2).
REQ-009 SHALL have port m_valE  in  DATA_W  ALU result.
REQ-010 SHALL have port m_valM  in  DATA_W  memory read value.
REQ-011 SHALL have port m_dstE  in  4  destination for valE.
REQ-012 SHALL have port m_dstM  in  4  destination for valM.
REQ-013 SHALL have port w_stall  in  1  hold W pipeline register.
REQ-014 SHALL have port w_bubble  in  1  load bubble into W register.
REQ-015 SHALL have port srcA  in  4  read port A address.
REQ-016 SHALL have port srcB  in  4  read port B address.
REQ-017 SHALL have port rvalA  out  DATA_W  read port A data.
REQ-018 SHALL have port rvalB  out  DATA_W  read port B data.
REQ-019 SHALL have port w_stat  out  3  status held in W register.
REQ-020 SHALL have port halted  out  1  sticky: exception/halt has retired.

Function
REQ-021 W register (stat, icode, valE, valM, dstE, dstM) SHALL load M inputs on rising clk when w_stall=0 and w_bubble=0.
REQ-022 w_stall=1 SHALL hold W unchanged; w_stall has priority over w_bubble when both are high.
REQ-023 w_bubble=1 (w_stall=0) SHALL load stat=BUB, icode=1 (nop), dstE=dstM=RNONE, valE=valM=0.
REQ-024 On capture, m_icode=2 with m_cnd=0 SHALL store dstE=RNONE (cmov not taken).
REQ-025 Register file SHALL be written on rising clk from current W contents: reg[W.dstE]<=W.valE, reg[W.dstM]<=W.valM, each only if ID!=RNONE and ID<NREG.
REQ-026 W.dstE==W.dstM (not RNONE) SHALL write W.valM (M port wins; popq %rsp case).
REQ-027 Writes SHALL be suppressed when halted=1 or W.stat is HLT, ADR or INS.
REQ-028 rvalA/rvalB SHALL be combinational; read of ID equal to a pending W.dstM/W.dstE write SHALL return that value (bypass, M over E), else reg contents; RNONE or ID>=NREG returns 0.
REQ-029 Bypass in REQ-028 SHALL be disabled under the suppression conditions of REQ-027.
REQ-030 halted SHALL set on the rising clk where W.stat is HLT, ADR or INS, and clear only on reset.
REQ-031 w_stat SHALL equal W.stat directly (no extra latency); write latency is one cycle from W capture to register file update.

Reset
REQ-032 rst_n low SHALL asynchronously clear all NREG registers to 0, load W with the bubble of REQ-023, clear halted.
REQ-033 Reset asserted mid-operation SHALL discard any pending write; first write after release occurs no earlier than second rising edge after deassertion.
REQ-034 Outputs during reset: rvalA=rvalB=0, w_stat=BUB, halted=0.

Structure
REQ-035 Stat codes, icode constants (NOP=1, CMOVXX=2, ...), RNONE and register IDs SHALL live in shared package y86_pkg.
REQ-036 Register file storage, write ports and bypass SHALL be one sub-module regfile_2w2r; W register and halt logic in the top.

Verification
REQ-037 irmovq: M{stat=1,icode=3,valE=64'h123456789ABCDEF0,dstE=1,dstM=F} -> after 2 edges reg[1]=that value; srcA=1 same cycle as W holds it returns value via bypass.
REQ-038 cmov not taken: icode=2,cnd=0,dstE=4,valE=64'hCAFEBABEDEADBEEF -> reg[4] unchanged; with cnd=1 reg[4]=CAFEBABEDEADBEEF.
REQ-039 popq: icode=B,dstE=4,valE=64'h8877665544332211,dstM=4,valM=64'hFACEFACEFACEFACE -> reg[4]=FACEFACEFACEFACE.
REQ-040 stall+bubble both high for 3 cycles -> W and register file unchanged; bubble alone -> w_stat=0, no write.
REQ-041 HLT: stat=2,icode=0 captured, then opq with dstE=3 -> halted=1 after one edge, reg[3] never written.
REQ-042 rst_n pulsed low mid-stream with W.dstE=5 pending -> reg[5]=0, halted=0, w_stat=0 immediately (asynchronous).
